// File: rtl/cell_pos_reader_if.sv
// Cell position reader bus bundle.
// Groups the control handshake, the cell memory read port and the
// position output stream of cell_pos_reader.
//   start/busy/done          : one-shot request and completion pulse
//   mem_address/rden/wren/q  : cell memory port (2-cycle read latency)
//   particle_count           : count latched from memory address 0
//   out_data/index/valid/last/ready : position stream, valid/ready handshake
// modport master : the reader side (drives memory port and stream)
// modport slave  : the environment side (memory, requester, consumer)
interface cell_pos_reader_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_rden;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_q;
    logic [ADDR_WIDTH-1:0] particle_count;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_index;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        input  start, mem_q, out_ready,
        output busy, done, mem_address, mem_rden, mem_wren, particle_count,
               out_data, out_index, out_valid, out_last
    );

    modport slave (
        output start, mem_q, out_ready,
        input  busy, done, mem_address, mem_rden, mem_wren, particle_count,
               out_data, out_index, out_valid, out_last
    );
endinterface

// File: rtl/cell_pos_reader.sv
// Cell position reader.
// On start, reads the particle count from cell memory address 0, then
// streams the positions at addresses 1..count through a 4-entry skid FIFO
// onto a valid/ready output, and pulses done when the stream is complete.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : cell_pos_reader_if.master (control, memory port, output stream)
module cell_pos_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input logic               clk,
    input logic               rst_n,
    cell_pos_reader_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT  = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam int                    FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_CNT,
        WAIT_CNT,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_mem_rden;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [ADDR_WIDTH-1:0] r_count;

    // Read-return pipeline mirroring the memory's 2-cycle latency
    logic [1:0]            r_pipe_v;
    logic [ADDR_WIDTH-1:0] r_pipe_addr0;
    logic [ADDR_WIDTH-1:0] r_pipe_addr1;

    logic [DATA_WIDTH-1:0] r_fifo_data  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_index [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_last;
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_fifo_cnt;

    logic [ADDR_WIDTH-1:0] w_count_raw;
    logic [ADDR_WIDTH-1:0] w_count_sat;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic [3:0]            w_level;
    logic                  w_can_issue;
    logic                  w_last_issued;
    logic                  w_drain_done;

    assign w_count_raw = bus.mem_q[ADDR_WIDTH-1:0];
    assign w_count_sat = (w_count_raw > MAX_COUNT) ? MAX_COUNT : w_count_raw;

    assign w_valid = (r_fifo_cnt != 3'd0);
    assign w_pop   = w_valid && bus.out_ready;
    // Address 0 is the count read; only data reads land in the FIFO
    assign w_push  = r_pipe_v[1] && (r_pipe_addr1 != '0);

    // Credit: reads in flight plus FIFO occupancy, after this cycle's pop,
    // must leave room for one more word so the FIFO can never overflow.
    assign w_level     = 4'(r_fifo_cnt) + 4'(r_mem_rden) + 4'(r_pipe_v[0]) + 4'(r_pipe_v[1]);
    assign w_can_issue = (w_level - 4'(w_pop)) < 4'd4;

    assign w_last_issued = r_mem_rden && (r_mem_address == r_count);

    // Look ahead one cycle so done follows the final transfer immediately
    assign w_drain_done = !r_mem_rden && (r_pipe_v == 2'b00) &&
                          ((r_fifo_cnt == 3'd0) || ((r_fifo_cnt == 3'd1) && w_pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mem_rden    <= 1'b0;
            r_mem_address <= '0;
            r_count       <= '0;
            r_pipe_v      <= '0;
            r_pipe_addr0  <= '0;
            r_pipe_addr1  <= '0;
        end else begin
            r_pipe_v     <= {r_pipe_v[0], r_mem_rden};
            r_pipe_addr0 <= r_mem_address;
            r_pipe_addr1 <= r_pipe_addr0;
            r_mem_rden   <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state       <= RD_CNT;
                        r_busy        <= 1'b1;
                        r_mem_rden    <= 1'b1;
                        r_mem_address <= '0;
                    end
                end
                RD_CNT: begin
                    r_state <= WAIT_CNT;
                end
                WAIT_CNT: begin
                    if (r_pipe_v[1]) begin
                        r_count <= w_count_sat;
                        if (w_count_sat == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            // First data read goes out on STREAM entry
                            r_state       <= STREAM;
                            r_mem_rden    <= 1'b1;
                            r_mem_address <= ADDR_WIDTH'(1);
                        end
                    end
                end
                STREAM: begin
                    if (w_last_issued) begin
                        r_state <= DRAIN;
                    end else if (w_can_issue) begin
                        r_mem_rden    <= 1'b1;
                        r_mem_address <= r_mem_address + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i]  <= '0;
                r_fifo_index[i] <= '0;
            end
            r_fifo_last <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr]  <= bus.mem_q;
                r_fifo_index[r_wr_ptr] <= r_pipe_addr1;
                r_fifo_last[r_wr_ptr]  <= (r_pipe_addr1 == r_count);
                r_wr_ptr               <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_fifo_cnt <= r_fifo_cnt + 3'(w_push) - 3'(w_pop);
        end
    end

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_rden       = r_mem_rden;
    assign bus.mem_wren       = 1'b0;
    assign bus.particle_count = r_count;
    assign bus.out_valid      = w_valid;
    // Head entry is gated so an empty FIFO presents all-zero outputs
    assign bus.out_data       = w_valid ? r_fifo_data[r_rd_ptr]  : '0;
    assign bus.out_index      = w_valid ? r_fifo_index[r_rd_ptr] : '0;
    assign bus.out_last       = w_valid && r_fifo_last[r_rd_ptr];

endmodule
